// File: rtl/blake_feed.sv
// Header feeder for a BLAKE hash core: collects a 20-word block header, then
// issues it repeatedly, adding the issue index to the low (nonce) word.
module blake_feed #(
  parameter int unsigned ISSUE_GAP = 1
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         start,
  input  logic [31:0]  nonce_count,
  input  logic         abort,
  output logic [639:0] din,
  output logic         ena,
  output logic         busy,
  output logic         done,
  output logic [31:0]  issued
);

  // state | meaning
  // LOAD  | accepting header words, s_ready high
  // ARMED | header complete, waiting for start
  // ISSUE | presenting one header to the core, ena high
  // GAP   | idle spacing between two issues
  typedef enum logic [1:0] {LOAD, ARMED, ISSUE, GAP} state_t;

  // Gap timer counts down to zero; GAP lasts ISSUE_GAP-1 cycles.
  localparam int unsigned GAP_CYC    = (ISSUE_GAP > 1) ? ISSUE_GAP - 2 : 0;
  localparam logic [7:0]  GAP_RELOAD = 8'(GAP_CYC);

  state_t         state_q, state_d;
  logic [4:0]     wcnt_q, wcnt_d;
  logic [639:0]   hdr_q, hdr_d;
  logic [31:0]    count_q, count_d;
  logic [31:0]    issued_q, issued_d;
  logic [7:0]     gap_q, gap_d;
  logic           done_q, done_d;

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q  <= LOAD;
      wcnt_q   <= '0;
      hdr_q    <= '0;
      count_q  <= '0;
      issued_q <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      hdr_q    <= hdr_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    hdr_d    = hdr_q;
    count_d  = count_q;
    issued_d = issued_q;
    gap_d    = gap_q;
    done_d   = 1'b0;

    case (state_q)
      LOAD: begin
        if (s_valid) begin
          // Shifting in from the bottom leaves word 0 at the top after 20 words.
          hdr_d = {hdr_q[607:0], s_data};
          if (wcnt_q == 5'd19) begin
            wcnt_d  = '0;
            state_d = ARMED;
          end else begin
            wcnt_d = wcnt_q + 5'd1;
          end
        end
      end
      ARMED: begin
        if (start) begin
          issued_d = '0;
          if (nonce_count != 32'd0) begin
            count_d = nonce_count;
            state_d = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        issued_d = issued_q + 32'd1;
        if (abort) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end else if (issued_d == count_q) begin
          state_d = LOAD;
          wcnt_d  = '0;
          done_d  = 1'b1;
        end else if (ISSUE_GAP > 1) begin
          state_d = GAP;
          gap_d   = GAP_RELOAD;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = LOAD;
          wcnt_d  = '0;
        end else if (gap_q == 8'd0) begin
          state_d = ISSUE;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign s_ready = (state_q == LOAD);
  assign ena     = (state_q == ISSUE);
  assign busy    = (state_q == ISSUE) || (state_q == GAP);
  assign done    = done_q;
  assign issued  = issued_q;
  assign din     = ena ? {hdr_q[639:32], hdr_q[31:0] + issued_q} : '0;

endmodule

// File: tb/tb_blake_feed.sv
// Bench for blake_feed: two instances (ISSUE_GAP 1 and 4) share stimulus;
// expected headers are queued when a sweep starts and compared on each ena.
module tb_blake_feed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstb, s_valid, start, abort;
  logic [31:0]  s_data, nonce_count;
  logic         s_ready, ena, busy, done;
  logic [639:0] din;
  logic [31:0]  issued;
  logic         s_ready4, ena4, busy4, done4;
  logic [639:0] din4;
  logic [31:0]  issued4;

  blake_feed #(.ISSUE_GAP(1)) dut (
    .clk(clk), .rstb(rstb), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .start(start), .nonce_count(nonce_count), .abort(abort),
    .din(din), .ena(ena), .busy(busy), .done(done), .issued(issued));

  blake_feed #(.ISSUE_GAP(4)) dut4 (
    .clk(clk), .rstb(rstb), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready4),
    .start(start), .nonce_count(nonce_count), .abort(abort),
    .din(din4), .ena(ena4), .busy(busy4), .done(done4), .issued(issued4));

  int total = 0;
  int bad = 0;

  logic [31:0]  hdr_w[20];
  logic [639:0] exp_q[$];
  logic [639:0] got_q[$];
  logic [31:0]  ena_m, done_m, busy_m;
  bit           leak;

  function automatic logic [639:0] hdr_val();
    logic [639:0] h = '0;
    for (int i = 0; i < 20; i++) h[639 - 32*i -: 32] = hdr_w[i];
    return h;
  endfunction

  task automatic set_header(input logic [31:0] last);
    hdr_w[0] = 32'h00000002;
    hdr_w[1] = 32'h5b4abb46;
    for (int i = 2; i < 19; i++) hdr_w[i] = 32'(i) * 32'h9E3779B9 + 32'h12345678;
    hdr_w[19] = last;
  endtask

  task automatic reset_dut();
    start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; nonce_count = '0;
    rstb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    exp_q.delete();
  endtask

  // Loads the 20 header words, then offers two extra words that must be ignored.
  task automatic load_header();
    for (int i = 0; i < 20; i++) begin
      s_data = hdr_w[i]; s_valid = 1'b1;
      @(negedge clk);
    end
    s_data = 32'hDEADBEEF;
    @(negedge clk);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  // Pulses start and queues the headers the sweep should produce.
  task automatic kick(input logic [31:0] n);
    logic [639:0] h = hdr_val();
    exp_q.delete();
    for (int k = 0; k < 32 && k < n; k++) exp_q.push_back({h[639:32], h[31:0] + 32'(k)});
    start = 1'b1; nonce_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records per-cycle activity for cycles 1..n after the current sample point.
  task automatic observe(input int n, input bit sel4, input int abort_c, input int rst_c);
    ena_m = '0; done_m = '0; busy_m = '0; leak = 0; got_q.delete();
    for (int c = 1; c <= n; c++) begin
      if (c > 1) @(negedge clk);
      if (sel4 ? ena4 : ena) begin
        ena_m[c] = 1'b1;
        got_q.push_back(sel4 ? din4 : din);
      end else if ((sel4 ? din4 : din) !== '0) begin
        leak = 1;
      end
      if (sel4 ? done4 : done) done_m[c] = 1'b1;
      if (sel4 ? busy4 : busy) busy_m[c] = 1'b1;
      abort = (c == abort_c);
      rstb  = (c != rst_c);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    total++; if (ena !== 1'b0) begin bad++; $display("FAIL reset_ena got=%b exp=0", ena); end
    total++; if (din !== '0) begin bad++; $display("FAIL reset_din got=%h exp=0", din); end
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
    total++; if (issued !== 32'd0) begin bad++; $display("FAIL reset_issued got=%h exp=0", issued); end
  endtask

  task automatic test_single();
    reset_dut();
    set_header(32'h0009e22e);
    load_header();
    total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL single_armed_s_ready got=%b exp=0", s_ready); end
    kick(32'd1);
    observe(6, 0, 0, 0);
    total++; if (ena_m !== 32'h2) begin bad++; $display("FAIL single_ena got=%h exp=%h", ena_m, 32'h2); end
    total++; if (done_m !== 32'h4) begin bad++; $display("FAIL single_done got=%h exp=%h", done_m, 32'h4); end
    total++; if (got_q[0] !== hdr_val()) begin bad++; $display("FAIL single_din got=%h exp=%h", got_q[0], hdr_val()); end
    total++; if (got_q[0][31:0] !== 32'h0009e22e) begin bad++; $display("FAIL single_nonce got=%h exp=0009e22e", got_q[0][31:0]); end
    total++; if (got_q[0][639:608] !== 32'h00000002) begin bad++; $display("FAIL single_word0 got=%h exp=00000002", got_q[0][639:608]); end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL single_din_idle got=%b exp=0", leak); end
    total++; if (issued !== 32'd1) begin bad++; $display("FAIL single_issued got=%h exp=1", issued); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL single_reload_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    set_header(32'h0009e22e);
    load_header();
    kick(32'd3);
    observe(8, 0, 0, 0);
    total++; if (ena_m !== 32'hE) begin bad++; $display("FAIL b2b_ena got=%h exp=%h", ena_m, 32'hE); end
    total++; if (busy_m !== 32'hE) begin bad++; $display("FAIL b2b_busy got=%h exp=%h", busy_m, 32'hE); end
    total++; if (done_m !== 32'h10) begin bad++; $display("FAIL b2b_done got=%h exp=%h", done_m, 32'h10); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_din%0d got=%h exp=%h", i, got_q[i][31:0], exp_q[i][31:0]); end
    end
    total++; if (got_q[2][31:0] !== 32'h0009e230) begin bad++; $display("FAIL b2b_nonce3 got=%h exp=0009e230", got_q[2][31:0]); end
    total++; if (issued !== 32'd3) begin bad++; $display("FAIL b2b_issued got=%h exp=3", issued); end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL b2b_din_idle got=%b exp=0", leak); end
  endtask

  task automatic test_wrap();
    reset_dut();
    set_header(32'hFFFFFFFF);
    load_header();
    kick(32'd2);
    observe(6, 0, 0, 0);
    total++; if (ena_m !== 32'h6) begin bad++; $display("FAIL wrap_ena got=%h exp=%h", ena_m, 32'h6); end
    total++; if (done_m !== 32'h8) begin bad++; $display("FAIL wrap_done got=%h exp=%h", done_m, 32'h8); end
    total++; if (got_q[1][31:0] !== 32'h00000000) begin bad++; $display("FAIL wrap_low got=%h exp=00000000", got_q[1][31:0]); end
    total++; if (got_q[1][639:32] !== got_q[0][639:32] || got_q[0] !== exp_q[0]) begin
      bad++; $display("FAIL wrap_upper got=%h exp=%h", got_q[1][639:32], exp_q[0][639:32]);
    end
  endtask

  task automatic test_gap();
    reset_dut();
    set_header(32'h0009e22e);
    load_header();
    kick(32'd3);
    observe(14, 1, 0, 0);
    total++; if (ena_m !== 32'h222) begin bad++; $display("FAIL gap_ena got=%h exp=%h", ena_m, 32'h222); end
    total++; if (done_m !== 32'h400) begin bad++; $display("FAIL gap_done got=%h exp=%h", done_m, 32'h400); end
    total++; if (busy_m !== 32'h3FE) begin bad++; $display("FAIL gap_busy got=%h exp=%h", busy_m, 32'h3FE); end
    total++; if (leak !== 1'b0) begin bad++; $display("FAIL gap_din_idle got=%b exp=0", leak); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL gap_din%0d got=%h exp=%h", i, got_q[i][31:0], exp_q[i][31:0]); end
    end
    total++; if (issued4 !== 32'd3) begin bad++; $display("FAIL gap_issued got=%h exp=3", issued4); end
  endtask

  task automatic test_abort();
    reset_dut();
    set_header(32'h0009e22e);
    load_header();
    kick(32'd10);
    observe(5, 0, 4, 0);
    total++; if (ena_m !== 32'h1E) begin bad++; $display("FAIL abort_ena got=%h exp=%h", ena_m, 32'h1E); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL abort_s_ready got=%b exp=1", s_ready); end
    total++; if (issued !== 32'd4) begin bad++; $display("FAIL abort_issued got=%h exp=4", issued); end
    for (int i = 0; i < got_q.size(); i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL abort_din%0d got=%h exp=%h", i, got_q[i][31:0], exp_q[i][31:0]); end
    end
    observe(10, 0, 0, 0);
    total++; if ({ena_m, done_m} !== 64'd0) begin bad++; $display("FAIL abort_quiet got=%h exp=0", {ena_m, done_m}); end
    kick(32'd5);
    observe(8, 0, 0, 0);
    total++; if ({ena_m, busy_m} !== 64'd0) begin bad++; $display("FAIL load_start_ignored got=%h exp=0", {ena_m, busy_m}); end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    set_header(32'h0009e22e);
    load_header();
    kick(32'd10);
    observe(4, 0, 0, 3);
    total++; if (ena_m !== 32'hE) begin bad++; $display("FAIL rstmid_ena got=%h exp=%h", ena_m, 32'hE); end
    total++; if ({ena, busy, s_ready} !== 3'b001) begin bad++; $display("FAIL rstmid_flags got=%b exp=001", {ena, busy, s_ready}); end
    total++; if (din !== '0) begin bad++; $display("FAIL rstmid_din got=%h exp=0", din); end
    total++; if (issued !== 32'd0) begin bad++; $display("FAIL rstmid_issued got=%h exp=0", issued); end
    observe(8, 0, 0, 0);
    total++; if ({ena_m, done_m} !== 64'd0) begin bad++; $display("FAIL rstmid_quiet got=%h exp=0", {ena_m, done_m}); end
    load_header();
    kick(32'd0);
    observe(5, 0, 0, 0);
    total++; if (done_m !== 32'h2) begin bad++; $display("FAIL zero_done got=%h exp=%h", done_m, 32'h2); end
    total++; if (ena_m !== 32'h0) begin bad++; $display("FAIL zero_ena got=%h exp=0", ena_m); end
    total++; if ({s_ready, issued} !== 33'd0) begin bad++; $display("FAIL zero_armed got=%h exp=0", {s_ready, issued}); end
    kick(32'd1);
    observe(4, 0, 0, 0);
    total++; if (ena_m !== 32'h2 || got_q[0] !== exp_q[0]) begin bad++; $display("FAIL zero_rearm got=%h exp=%h", ena_m, 32'h2); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_gap();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
